mux_reg_n_to_1: RTL and testbench

Parametrised, registered N-to-1 word multiplexer with a valid/ready handshake and a two-entry skid buffer. It selects one of NUM_IN input words of WIDTH bits and presents it one cycle later, so back-pressure from the consumer does not drop data. It replaces fixed-width 2:1 muxes at datapath points that need registering, such as forwarding and writeback selection between pipeline stages.

---
 rtl/mux_pkg.sv | 19 +
 rtl/mux_sel_n_to_1.sv | 23 ++
 rtl/mux_reg_n_to_1.sv | 117 +++++++++++
 tb/tb_mux_reg_n_to_1.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the registered datapath multiplexers: default sizes
// and the clog2 helper used to derive select widths.
package mux_pkg;

    localparam int MUX_DEF_WIDTH  = 64;
    localparam int MUX_DEF_NUM_IN = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_sel_n_to_1.sv
// Combinational NUM_IN-to-1 word selector; a select value with no matching
// word yields all-zeros.
module mux_sel_n_to_1
    import mux_pkg::*;
#(
    parameter  int WIDTH  = MUX_DEF_WIDTH,
    parameter  int NUM_IN = MUX_DEF_NUM_IN,
    localparam int SEL_W  = clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        word
);

    // AND-OR select: only the matching lane contributes, so out-of-range gives zero
    always_comb begin
        word = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            word = word | (in_data[i*WIDTH +: WIDTH] & {WIDTH{(int'(sel) == i)}});
        end
    end

endmodule

// File: rtl/mux_reg_n_to_1.sv
// Registered N-to-1 word mux with valid/ready handshake and a two-entry skid
// buffer. Define MUX_REG_SEL_ERR_EN to add the sticky sel_err output.
module mux_reg_n_to_1
    import mux_pkg::*;
#(
    parameter  int WIDTH  = MUX_DEF_WIDTH,
    parameter  int NUM_IN = MUX_DEF_NUM_IN,
    localparam int SEL_W  = clog2(NUM_IN)
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef MUX_REG_SEL_ERR_EN
    ,
    output logic                    sel_err
`endif
);

    logic [WIDTH-1:0] word_s;
    logic [WIDTH-1:0] main_data_r, main_data_nxt_s;
    logic [WIDTH-1:0] skid_data_r, skid_data_nxt_s;
    logic             main_valid_r, main_valid_nxt_s;
    logic             skid_valid_r, skid_valid_nxt_s;
    logic             in_fire_s;
    logic             out_fire_s;

    mux_sel_n_to_1 #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_sel (
        .in_data (in_data),
        .sel     (sel),
        .word    (word_s)
    );

    // in_ready only looks at the skid flag and reset, never at out_ready
    assign in_ready   = !skid_valid_r && !Rst;
    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = main_valid_r && out_ready;
    assign out_data   = main_data_r;
    assign out_valid  = main_valid_r;

    // Next-state for the main/skid entries; flush clears valids but keeps data
    always_comb begin
        main_data_nxt_s  = main_data_r;
        main_valid_nxt_s = main_valid_r;
        skid_data_nxt_s  = skid_data_r;
        skid_valid_nxt_s = skid_valid_r;
        if (flush) begin
            main_valid_nxt_s = 1'b0;
            skid_valid_nxt_s = 1'b0;
        end else if (out_fire_s) begin
            if (skid_valid_r) begin
                main_data_nxt_s  = skid_data_r;
                main_valid_nxt_s = 1'b1;
                skid_valid_nxt_s = 1'b0;
            end else if (in_fire_s) begin
                main_data_nxt_s  = word_s;
                main_valid_nxt_s = 1'b1;
            end else begin
                main_valid_nxt_s = 1'b0;
            end
        end else if (in_fire_s) begin
            if (main_valid_r) begin
                skid_data_nxt_s  = word_s;
                skid_valid_nxt_s = 1'b1;
            end else begin
                main_data_nxt_s  = word_s;
                main_valid_nxt_s = 1'b1;
            end
        end else begin
            main_valid_nxt_s = main_valid_r;
        end
    end

    // Storage registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            main_data_r  <= {WIDTH{1'b0}};
            main_valid_r <= 1'b0;
            skid_data_r  <= {WIDTH{1'b0}};
            skid_valid_r <= 1'b0;
        end else begin
            main_data_r  <= main_data_nxt_s;
            main_valid_r <= main_valid_nxt_s;
            skid_data_r  <= skid_data_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
        end
    end

`ifdef MUX_REG_SEL_ERR_EN
    logic sel_oor_s;
    logic sel_err_r;

    assign sel_oor_s = (int'(sel) >= NUM_IN);
    assign sel_err   = sel_err_r;

    // Sticky out-of-range flag; only reset clears it
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sel_err_r <= 1'b0;
        end else if (in_fire_s && sel_oor_s) begin
            sel_err_r <= 1'b1;
        end else begin
            sel_err_r <= sel_err_r;
        end
    end
`endif

endmodule

// File: tb/tb_mux_reg_n_to_1.sv
// Directed bench for mux_reg_n_to_1: vector table, flush/reset/select-error
// sequences and a randomised FIFO scoreboard.
module tb_mux_reg_n_to_1;

    logic         clk;
    logic         rst;
    logic [255:0] in_data;
    logic [1:0]   sel;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    logic [63:0]  out_data;
    logic         out_valid;
    logic         out_ready;

    logic         rst2;
    logic [23:0]  in_data2;
    logic [1:0]   sel2;
    logic         in_valid2;
    logic         in_ready2;
    logic         flush2;
    logic [7:0]   out_data2;
    logic         out_valid2;
    logic         out_ready2;
`ifdef MUX_REG_SEL_ERR_EN
    logic         sel_err1;
    logic         sel_err2;
`endif

    int checks;
    int failures;

    mux_reg_n_to_1 #(.WIDTH(64), .NUM_IN(4)) dut (
        .Clk(clk), .Rst(rst), .in_data(in_data), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_REG_SEL_ERR_EN
        , .sel_err(sel_err1)
`endif
    );

    mux_reg_n_to_1 #(.WIDTH(8), .NUM_IN(3)) dut3 (
        .Clk(clk), .Rst(rst2), .in_data(in_data2), .sel(sel2),
        .in_valid(in_valid2), .in_ready(in_ready2), .flush(flush2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2)
`ifdef MUX_REG_SEL_ERR_EN
        , .sel_err(sel_err2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [1:0]  s;
        logic        orr;
        logic        fl;
        logic        ir;
        logic        ov;
        logic [63:0] od;
    } vec_t;

    vec_t tbl [11];
    logic [63:0] q [$];

    function automatic logic [63:0] wd(input int i);
        return 64'h1111_0000_0000_0000 | 64'(i);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one cycle: drive at negedge, check in_ready pre-edge, outputs post-edge
    task automatic step(input string name, input logic iv, input logic [1:0] s,
                        input logic orr, input logic fl, input logic ir,
                        input logic ov, input logic [63:0] od);
        @(negedge clk);
        in_valid = iv; sel = s; out_ready = orr; flush = fl;
        #1 chk({name, "_in_ready"}, 64'(in_ready), 64'(ir));
        @(posedge clk);
        #1;
        chk({name, "_out_valid"}, 64'(out_valid), 64'(ov));
        chk({name, "_out_data"}, out_data, od);
    endtask

    initial begin
        int pre;
        logic iv, orr, in_f, out_f;
        logic [1:0] s;
        logic [63:0] exp_w;

        checks = 0; failures = 0;
        rst = 1'b1; rst2 = 1'b1;
        in_data = {wd(3), wd(2), wd(1), wd(0)};
        sel = 2'd0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_data2 = {8'hC3, 8'hB2, 8'hA1};
        sel2 = 2'd0; in_valid2 = 1'b0; flush2 = 1'b0; out_ready2 = 1'b1;

        // streaming then backpressure A/B/C
        tbl[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, wd(0)};
        tbl[1]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, wd(1)};
        tbl[2]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, wd(2)};
        tbl[3]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, wd(3)};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, wd(3)};
        tbl[5]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, wd(0)};
        tbl[6]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, wd(0)};
        tbl[7]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, wd(0)};
        tbl[8]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, wd(1)};
        tbl[9]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, wd(2)};
        tbl[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, wd(2)};

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        @(negedge clk);
        rst = 1'b0; rst2 = 1'b0;
        #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 11; i++) begin
            step($sformatf("vec%0d", i), tbl[i].iv, tbl[i].s, tbl[i].orr, tbl[i].fl,
                 tbl[i].ir, tbl[i].ov, tbl[i].od);
        end

        // flush with both entries full and input offered
        step("fl_fill0", 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, wd(0));
        step("fl_fill1", 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, wd(0));
        step("fl_flush", 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, wd(0));
        step("fl_after", 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, wd(0));

        // reset mid-stream with skid full
        step("rs_fill0", 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, wd(2));
        step("rs_fill1", 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, wd(2));
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; sel = 2'd0; out_ready = 1'b1;
        #1 chk("rs_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rs_out_valid", 64'(out_valid), 64'd0);
        chk("rs_out_data", out_data, 64'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1 chk("rs_release_in_ready", 64'(in_ready), 64'd1);
        step("rs_idle", 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0);
        step("rs_send", 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, wd(1));
        step("rs_drain", 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, wd(1));

        // randomised accept/drain against a FIFO model
        for (int c = 0; c < 104; c++) begin
            @(negedge clk);
            iv  = (c < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
            orr = (c < 100) ? 1'($urandom_range(0, 1)) : 1'b1;
            s   = 2'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) begin
                in_data[k*64 +: 64] = {32'(c), 32'(k)};
            end
            in_valid = iv; sel = s; out_ready = orr; flush = 1'b0;
            #1;
            pre   = q.size();
            chk("rnd_in_ready", 64'(in_ready), 64'(pre < 2));
            chk("rnd_out_valid", 64'(out_valid), 64'(pre > 0));
            out_f = (pre > 0) && orr;
            in_f  = iv && (pre < 2);
            if (out_f) begin
                exp_w = q.pop_front();
                chk("rnd_out_data", out_data, exp_w);
            end
            if (in_f) begin
                q.push_back({32'(c), 32'(s)});
            end
            @(posedge clk);
        end
        chk("rnd_all_delivered", 64'(q.size()), 64'd0);

        // NUM_IN=3 instance: in-range select, then out-of-range select
        @(negedge clk);
        in_valid2 = 1'b1; sel2 = 2'd2;
        @(posedge clk);
        #1;
        chk("n3_sel2_valid", 64'(out_valid2), 64'd1);
        chk("n3_sel2_data", 64'(out_data2), 64'h00C3);
`ifdef MUX_REG_SEL_ERR_EN
        chk("n3_sel_err_clear", 64'(sel_err2), 64'd0);
`endif
        @(negedge clk);
        sel2 = 2'd3;
        @(posedge clk);
        #1;
        chk("n3_oor_valid", 64'(out_valid2), 64'd1);
        chk("n3_oor_data", 64'(out_data2), 64'd0);
`ifdef MUX_REG_SEL_ERR_EN
        chk("n3_sel_err_set", 64'(sel_err2), 64'd1);
`endif
        @(negedge clk);
        in_valid2 = 1'b0; flush2 = 1'b1;
        @(posedge clk);
        #1;
        chk("n3_flush_valid", 64'(out_valid2), 64'd0);
`ifdef MUX_REG_SEL_ERR_EN
        chk("n3_sel_err_after_flush", 64'(sel_err2), 64'd1);
`endif
        @(negedge clk);
        flush2 = 1'b0; rst2 = 1'b1;
        @(posedge clk);
        #1;
        chk("n3_rst_valid", 64'(out_valid2), 64'd0);
`ifdef MUX_REG_SEL_ERR_EN
        chk("n3_sel_err_after_rst", 64'(sel_err2), 64'd0);
        chk("n4_sel_err_never", 64'(sel_err1), 64'd0);
`endif
        @(negedge clk);
        rst2 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
